// File: rtl/hazard_unit.sv
// Hazard controller for the 5-stage RV64IM pipeline: forwarding selects, load-use,
// branch and divide stall/flush control. Define HAZARD_DIV_STALL_EN to build the divide FSM.
module hazard_unit #(
    parameter int DIV_CYCLES = 34
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [4:0] Rs1D,
    input  logic [4:0] Rs2D,
    input  logic [4:0] Rs1E,
    input  logic [4:0] Rs2E,
    input  logic [4:0] RdE,
    input  logic       enableE,
    input  logic       RegWriteE,
    input  logic       LoadE,
    input  logic [5:0] ALUControlE,
    input  logic       PCSrcE,
    output logic [1:0] FrowardAE,
    output logic [1:0] FrowardBE,
    output logic       StallF,
    output logic       StallD,
    output logic       StallE,
    output logic       FlushD,
    output logic       FlushE
);

    logic [4:0] RdM;
    logic       RegWriteM;
    logic [4:0] RdW;
    logic       RegWriteW;
    logic       lwStall;
    logic       divStall;

    // Shadow copy of the M/W destination fields; a stalled E pushes a bubble into M.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            RdM       <= 5'd0;
            RegWriteM <= 1'b0;
            RdW       <= 5'd0;
            RegWriteW <= 1'b0;
        end else begin
            RdW       <= RdM;
            RegWriteW <= RegWriteM;
            if (!StallE) begin
                RdM       <= RdE;
                RegWriteM <= RegWriteE & enableE;
            end else begin
                RegWriteM <= 1'b0;
            end
        end
    end

    logic [4:0] rsE    [2];
    logic [1:0] fwdSel [2];

    assign rsE[0] = Rs1E;
    assign rsE[1] = Rs2E;

    // M has priority over W; x0 is never forwarded.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : gFwd
            logic hitM;
            logic hitW;
            assign hitM = RegWriteM && (RdM != 5'd0) && (RdM == rsE[gi]);
            assign hitW = RegWriteW && (RdW != 5'd0) && (RdW == rsE[gi]);
            assign fwdSel[gi] = hitM ? 2'b10 : (hitW ? 2'b01 : 2'b00);
        end
    endgenerate

    assign FrowardAE = fwdSel[0];
    assign FrowardBE = fwdSel[1];

    assign lwStall = enableE & LoadE & (RdE != 5'd0) & ((RdE == Rs1D) | (RdE == Rs2D));

`ifdef HAZARD_DIV_STALL_EN
    localparam logic [0:0] IDLE    = 1'b0;
    localparam logic [0:0] DIVWAIT = 1'b1;

    logic [0:0] stateReg;
    logic [0:0] stateNext;
    logic [7:0] cntReg;
    logic [7:0] cntNext;
    logic       divE;
    logic       unusedAluBit;

    assign unusedAluBit = ALUControlE[5];
    assign divE = enableE && (ALUControlE[4:0] >= 5'd6) && (ALUControlE[4:0] <= 5'd9);

    // The first stall cycle is spent in IDLE, so the counter covers the remaining DIV_CYCLES-2.
    always_comb begin
        stateNext = stateReg;
        cntNext   = cntReg;
        divStall  = 1'b0;
        case (stateReg)
            IDLE: begin
                if (divE && (DIV_CYCLES > 1)) begin
                    divStall  = 1'b1;
                    stateNext = DIVWAIT;
                    cntNext   = 8'(DIV_CYCLES - 2);
                end
            end
            DIVWAIT: begin
                if (cntReg != 8'd0) begin
                    divStall = 1'b1;
                    cntNext  = cntReg - 8'd1;
                end else begin
                    stateNext = IDLE;
                end
            end
            default: begin
                stateNext = IDLE;
                cntNext   = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stateReg <= IDLE;
            cntReg   <= 8'd0;
        end else begin
            stateReg <= stateNext;
            cntReg   <= cntNext;
        end
    end
`else
    logic [5:0] unusedAluControl;

    assign unusedAluControl = ALUControlE;
    assign divStall         = 1'b0;
`endif

    assign StallF = lwStall | divStall;
    assign StallD = lwStall | divStall;
    assign StallE = divStall;
    assign FlushE = (lwStall | PCSrcE) & ~divStall;
    assign FlushD = PCSrcE;

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: per-cycle vector table driven through a
// scoreboard queue, plus hand sequences for reset-mid-divide and divide length.
module tb_hazard_unit;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE;
    logic       enableE, RegWriteE, LoadE, PCSrcE;
    logic [5:0] ALUControlE;

    logic [1:0] fa4, fb4, fa34, fb34;
    logic       sf4, sd4, se4, fd4, fe4;
    logic       sf34, sd34, se34, fd34, fe34;

    int checks   = 0;
    int failures = 0;

`ifdef HAZARD_DIV_STALL_EN
    localparam logic DIVON = 1'b1;
`else
    localparam logic DIVON = 1'b0;
`endif

    always #5 clk = ~clk;

    hazard_unit #(.DIV_CYCLES(4)) dut4 (
        .clk(clk), .reset_n(reset_n),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
        .enableE(enableE), .RegWriteE(RegWriteE), .LoadE(LoadE),
        .ALUControlE(ALUControlE), .PCSrcE(PCSrcE),
        .FrowardAE(fa4), .FrowardBE(fb4),
        .StallF(sf4), .StallD(sd4), .StallE(se4), .FlushD(fd4), .FlushE(fe4)
    );

    hazard_unit #(.DIV_CYCLES(34)) dut34 (
        .clk(clk), .reset_n(reset_n),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
        .enableE(enableE), .RegWriteE(RegWriteE), .LoadE(LoadE),
        .ALUControlE(ALUControlE), .PCSrcE(PCSrcE),
        .FrowardAE(fa34), .FrowardBE(fb34),
        .StallF(sf34), .StallD(sd34), .StallE(se34), .FlushD(fd34), .FlushE(fe34)
    );

    typedef struct packed {
        logic [4:0] rs1D;
        logic [4:0] rs2D;
        logic [4:0] rs1E;
        logic [4:0] rs2E;
        logic [4:0] rdE;
        logic       en;
        logic       rw;
        logic       ld;
        logic [5:0] alu;
        logic       pc;
        logic [8:0] exp;   // {FrowardAE, FrowardBE, StallF, StallD, StallE, FlushD, FlushE}
    } vec_t;

    localparam int NVEC = 31;
    vec_t       vecs [NVEC];
    logic [8:0] expQ [$];

    function automatic logic [8:0] e(logic [1:0] fa, logic [1:0] fb, logic sfd,
                                     logic se, logic fd, logic fe);
        return {fa, fb, sfd, sfd, se, fd, fe};
    endfunction

    function automatic vec_t mk(logic [4:0] rs1D, logic [4:0] rs2D, logic [4:0] rs1E,
                                logic [4:0] rs2E, logic [4:0] rdE, logic en, logic rw,
                                logic ld, logic [5:0] alu, logic pc, logic [8:0] exp);
        vec_t v;
        v.rs1D = rs1D; v.rs2D = rs2D; v.rs1E = rs1E; v.rs2E = rs2E; v.rdE = rdE;
        v.en = en; v.rw = rw; v.ld = ld; v.alu = alu; v.pc = pc; v.exp = exp;
        return v;
    endfunction

    function automatic logic [8:0] out4();
        return {fa4, fb4, sf4, sd4, se4, fd4, fe4};
    endfunction

    function automatic logic [8:0] out34();
        return {fa34, fb34, sf34, sd34, se34, fd34, fe34};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic drive(input vec_t v);
        Rs1D = v.rs1D; Rs2D = v.rs2D; Rs1E = v.rs1E; Rs2E = v.rs2E; RdE = v.rdE;
        enableE = v.en; RegWriteE = v.rw; LoadE = v.ld; ALUControlE = v.alu; PCSrcE = v.pc;
    endtask

    task automatic zeroInputs();
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 6'd0, 0, 9'd0));
    endtask

    initial begin
        logic [8:0] want;
        int  nStall;
        bit  done;

        reset_n = 1'b0;
        zeroInputs();

        // Rows are consecutive cycles; expected values are hand-derived from the history above them.
        vecs[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 6'd0, 0, e(0, 0, 0, 0, 0, 0));
        vecs[1]  = mk(0, 0, 0, 0, 5, 1, 1, 0, 6'd0, 0, e(0, 0, 0, 0, 0, 0));
        vecs[2]  = mk(0, 0, 5, 0, 0, 1, 0, 0, 6'd0, 0, e(2, 0, 0, 0, 0, 0));
        vecs[3]  = mk(0, 0, 5, 5, 0, 1, 0, 0, 6'd0, 0, e(1, 1, 0, 0, 0, 0));
        vecs[4]  = mk(0, 0, 0, 0, 0, 1, 1, 0, 6'd0, 0, e(0, 0, 0, 0, 0, 0));
        vecs[5]  = mk(0, 0, 0, 0, 0, 1, 0, 0, 6'd0, 0, e(0, 0, 0, 0, 0, 0));
        vecs[6]  = mk(0, 0, 0, 0, 0, 1, 0, 0, 6'd0, 0, e(0, 0, 0, 0, 0, 0));
        vecs[7]  = mk(0, 0, 0, 0, 7, 1, 1, 0, 6'd0, 0, e(0, 0, 0, 0, 0, 0));
        vecs[8]  = mk(0, 0, 0, 7, 7, 1, 1, 0, 6'd0, 0, e(0, 2, 0, 0, 0, 0));
        vecs[9]  = mk(0, 0, 7, 7, 0, 1, 0, 0, 6'd0, 0, e(2, 2, 0, 0, 0, 0));
        vecs[10] = mk(0, 0, 3, 7, 0, 1, 0, 0, 6'd0, 0, e(0, 1, 0, 0, 0, 0));
        vecs[11] = mk(6, 0, 0, 0, 6, 0, 1, 1, 6'd6, 0, e(0, 0, 0, 0, 0, 0));
        vecs[12] = mk(0, 0, 6, 0, 0, 1, 0, 0, 6'd0, 0, e(0, 0, 0, 0, 0, 0));
        vecs[13] = mk(0, 0, 6, 0, 0, 1, 0, 0, 6'd0, 0, e(0, 0, 0, 0, 0, 0));
        vecs[14] = mk(0, 9, 0, 0, 9, 1, 1, 1, 6'd0, 0, e(0, 0, 1, 0, 0, 1));
        vecs[15] = mk(0, 9, 0, 0, 0, 0, 0, 0, 6'd0, 0, e(0, 0, 0, 0, 0, 0));
        vecs[16] = mk(0, 0, 0, 9, 0, 1, 0, 0, 6'd0, 0, e(0, 1, 0, 0, 0, 0));
        vecs[17] = mk(0, 0, 0, 0, 0, 1, 1, 1, 6'd0, 0, e(0, 0, 0, 0, 0, 0));
        vecs[18] = mk(12, 3, 0, 0, 12, 1, 1, 1, 6'd0, 0, e(0, 0, 1, 0, 0, 1));
        vecs[19] = mk(0, 0, 0, 0, 0, 1, 0, 0, 6'd0, 1, e(0, 0, 0, 0, 1, 1));
        vecs[20] = mk(0, 0, 12, 0, 0, 1, 0, 0, 6'd0, 0, e(1, 0, 0, 0, 0, 0));
        vecs[21] = mk(0, 0, 0, 0, 10, 1, 1, 0, 6'h27, 0, e(0, 0, DIVON, DIVON, 0, 0));
        vecs[22] = mk(0, 0, 0, 0, 10, 1, 1, 0, 6'h27, 0, e(0, 0, DIVON, DIVON, 0, 0));
        vecs[23] = mk(0, 0, 0, 0, 10, 1, 1, 0, 6'h27, 0, e(0, 0, DIVON, DIVON, 0, 0));
        vecs[24] = mk(0, 0, 0, 0, 10, 1, 1, 0, 6'h27, 0, e(0, 0, 0, 0, 0, 0));
        vecs[25] = mk(0, 0, 10, 0, 11, 1, 1, 0, 6'd9, 0, e(2, 0, DIVON, DIVON, 0, 0));
        vecs[26] = mk(0, 0, 10, 0, 11, 1, 1, 0, 6'd9, 0, e(1, 0, DIVON, DIVON, 0, 0));
        vecs[27] = mk(0, 0, 10, 0, 11, 1, 1, 0, 6'd9, 0, e(0, 0, DIVON, DIVON, 0, 0));
        vecs[28] = mk(0, 0, 10, 0, 11, 1, 1, 0, 6'd9, 0, e(0, 0, 0, 0, 0, 0));
        vecs[29] = mk(0, 0, 0, 11, 0, 1, 0, 0, 6'd5, 0, e(0, 2, 0, 0, 0, 0));
        vecs[30] = mk(0, 0, 0, 11, 0, 1, 0, 0, 6'd10, 0, e(0, 1, 0, 0, 0, 0));

        #3;
        chk("reset_outputs_dut4", 32'(out4()), 32'd0);
        chk("reset_outputs_dut34", 32'(out34()), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            @(posedge clk);
            #1;
            drive(vecs[i]);
            expQ.push_back(vecs[i].exp);
            @(negedge clk);
            want = expQ.pop_front();
            $display("vec %0d out=%03h exp=%03h", i, out4(), want);
            chk($sformatf("vec%0d", i), 32'(out4()), 32'(want));
        end

        // dut34 entered its long divide at vec 21 and must still be busy.
        @(posedge clk);
        #1;
        zeroInputs();
        @(negedge clk);
        chk("div34_still_busy", 32'(se34), 32'(DIVON));

        reset_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        // Reset during the second stall cycle of a 34-cycle divide.
        @(posedge clk);
        #1;
        drive(mk(0, 0, 0, 0, 4, 1, 1, 0, 6'd8, 0, 9'd0));
        @(negedge clk);
        chk("div34_stall_cycle1", 32'(se34), 32'(DIVON));
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("div34_stall_cycle2", 32'(se34), 32'(DIVON));
        #1;
        reset_n = 1'b0;
        zeroInputs();
        #1;
        chk("div34_reset_drop_stallE", 32'(se34), 32'd0);
        chk("div34_reset_drop_stallF", 32'(sf34), 32'd0);
        $display("reset mid-divide stallE=%0d", se34);
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("post_reset_dut34", 32'(out34()), 32'd0);
        @(negedge clk);
        chk("post_reset_idle_dut34", 32'(out34()), 32'd0);
        chk("post_reset_idle_dut4", 32'(out4()), 32'd0);

        // A fresh 34-cycle divide must stall for exactly 33 cycles.
        @(posedge clk);
        #1;
        drive(mk(0, 0, 0, 0, 4, 1, 1, 0, 6'd7, 0, 9'd0));
        nStall = 0;
        done   = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            if (se34) nStall++;
            else done = 1'b1;
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL div34_length timeout actual=%0d required=done", nStall);
        end else begin
            $display("div34 stall cycles=%0d", nStall);
            chk("div34_length", 32'(nStall), DIVON ? 32'd33 : 32'd0);
        end
        @(posedge clk);
        #1;
        zeroInputs();
        @(negedge clk);
        chk("final_idle_dut34", 32'(out34()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Pipeline hazard controller for the 5-stage RV64IM core. It is the producing end of the execute-stage forwarding interface: it drives the `FrowardAE`/`FrowardBE` selects that the execute-stage ALU consumes. It also generates the stall and flush controls for load-use hazards, taken branches and jumps, and multi-cycle divide/remainder operations. It keeps its own shadow copy of the M- and W-stage destination registers and sequences divide stalls with a counter FSM.

## Interface
Parameters:
- `DIV_CYCLES`, default 34: total cycles a div/rem op occupies E; legal range 1..255.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `Rs1D` input 5: rs1 of the instruction in D.
- `Rs2D` input 5: rs2 of the instruction in D.
- `Rs1E` input 5: rs1 of the instruction in E.
- `Rs2E` input 5: rs2 of the instruction in E.
- `RdE` input 5: destination register of the instruction in E.
- `enableE` input 1: E holds a valid instruction (0 = bubble).
- `RegWriteE` input 1: the E instruction writes the register file.
- `LoadE` input 1: the E instruction is a load.
- `ALUControlE` input 6: ALU opcode; `[4:0]` in 6..9 means div/divu/rem/remu, including W variants.
- `PCSrcE` input 1: a branch is taken or a jump is in E.
- `FrowardAE` output 2: SrcA select; 00 = RD1E, 01 = ResultW, 10 = ALUResultM.
- `FrowardBE` output 2: WriteData select; same encoding as `FrowardAE`.
- `StallF` output 1: hold the PC.
- `StallD` output 1: hold the D pipeline register.
- `StallE` output 1: hold the E pipeline register.
- `FlushD` output 1: clear the D pipeline register.
- `FlushE` output 1: clear the E pipeline register.

## Operation
- **Shadow pipeline.** Registers `RdM`, `RegWriteM`, `RdW`, `RegWriteW`.
  - Each edge: `RdW`/`RegWriteW` <= `RdM`/`RegWriteM`.
  - If `StallE` = 0: `RdM`/`RegWriteM` <= `RdE`/(`RegWriteE` & `enableE`).
  - If `StallE` = 1: `RegWriteM` <= 0 (a bubble enters M).
- **Forwarding A** (combinational):
  - 10 if `RegWriteM` && `RdM` != 0 && `RdM` == `Rs1E`;
  - else 01 if `RegWriteW` && `RdW` != 0 && `RdW` == `Rs1E`;
  - else 00.
  - M has priority over W. x0 is never forwarded.
- **Forwarding B**: identical to A, using `Rs2E`.
- **Load-use.** `lwStall` = `enableE` & `LoadE` & (`RdE` != 0) & (`RdE` == `Rs1D` | `RdE` == `Rs2D`).
  - Effect: `StallF` = `StallD` = 1 and `FlushE` = 1 for exactly one cycle.
- **Control hazard.** `PCSrcE` = 1 gives `FlushD` = `FlushE` = 1 in the same cycle.
- **Divide FSM.** States IDLE and DIVWAIT, with an 8-bit `cnt`. `divE` = `enableE` & (`ALUControlE[4:0]` in 6..9).
  - IDLE with `divE` and `DIV_CYCLES` > 1: `divStall` = 1. Next state is DIVWAIT, `cnt` <= `DIV_CYCLES` − 2.
  - DIVWAIT with `cnt` != 0: `divStall` = 1, `cnt` decrements.
  - DIVWAIT with `cnt` == 0: `divStall` = 0, next state IDLE. E advances on this edge, so a back-to-back div in E restarts the count from IDLE.
  - `divStall` drives `StallF` = `StallD` = `StallE` = 1.
- **Output combination.**
  - `StallF` = `StallD` = `lwStall` | `divStall`.
  - `StallE` = `divStall`.
  - `FlushE` = `lwStall` | `PCSrcE`, masked to 0 while `divStall` = 1.
  - `FlushD` = `PCSrcE`.
  - A load, a taken branch and a div are mutually exclusive in E, so no further priority is needed.

## Timing
- Forward selects, stalls and flushes are combinational from the inputs plus registered state, valid in the same cycle.
- The shadow M/W state lags E by 1 and 2 cycles respectively.
- Div occupancy of E is exactly `DIV_CYCLES` cycles, of which `DIV_CYCLES` − 1 are stall cycles. `DIV_CYCLES` = 1 produces no stall and no FSM transition.
- Reset values:
  - Registers: state IDLE, `cnt` = 0, `RdM` = `RdW` = 0, `RegWriteM` = `RegWriteW` = 0.
  - Outputs: `FrowardAE` = `FrowardBE` = 00. With all inputs 0, every stall and flush output is 0.
- Reset asserted mid-divide: the FSM returns to IDLE asynchronously and `divStall` drops immediately.
- `enableE` = 0 in E: no div stall, no load-use, and a bubble enters M.

## Configuration
- Macro `HAZARD_DIV_STALL_EN`.
- Defined: the divide FSM, `cnt` and `divStall` are built as described above.
- Undefined:
  - The FSM and counter are removed and `divStall` is constant 0, so `StallE` is tied to 0.
  - The divider is assumed single-cycle and `DIV_CYCLES` is ignored.
  - Forwarding, load-use and flush behaviour are unchanged.

## Test plan
- Forward from M: `add x5` in E with `RegWriteE` = 1. Next cycle `Rs1E` = 5 → `FrowardAE` = 10. The cycle after, `Rs1E` = 5 → `FrowardAE` = 01.
- x0 and priority:
  - `RdE` = 0 writes → `FrowardAE` = 00 two cycles later.
  - x7 written in two consecutive cycles, then `Rs2E` = 7 → `FrowardBE` = 10.
- Load-use: `LoadE` = 1, `RdE` = 9, `Rs2D` = 9 → one cycle of `StallF` = `StallD` = `FlushE` = 1; all 0 the next cycle once the load has moved to M.
- Branch: `PCSrcE` = 1 → `FlushD` = `FlushE` = 1 that cycle, no stalls.
- Divide with `DIV_CYCLES` = 4:
  - `divE` held → `StallE` = 1 for 3 cycles, then 0 on the 4th.
  - M shadow receives bubbles during the stall.
  - A back-to-back second div yields another 3 stall cycles.
- Reset at the 2nd stall cycle of a `DIV_CYCLES` = 34 divide → `StallE` drops immediately. After release with `divE` = 0: state IDLE and `FrowardAE` = `FrowardBE` = 00.
